fma_issue_arbiter: RTL and testbench
====================================

Name: fma_issue_arbiter

Overview:
- Shares the FMA issue port (the abc line plus its valid and new-c flags) between REQ_COUNT requesters, e.g. the memory module and a future second compute source.
- Grants one requester per cycle, round-robin, with a valid/ready handshake.
- Records the owner of each issued line in a tag FIFO, then routes the matching line returned by fma_write_buffer back to that owner.
- Sits between the requesters and the FMA pair, all on clk_pixel.

Parameters:
- REQ_COUNT, 2, number of requesters (2..8).
- LINE_WIDTH, 96, width of one abc issue line (3*WORD_WIDTH*FMA_COUNT).
- RESULT_WIDTH, 96, width of one write-buffer result line.
- TAG_DEPTH, 16, maximum number of lines in flight; this is the tag FIFO depth, a power of two.

Ports:
- clk_in  in  1  pixel clock; the only clock.
- rst_in  in  1  reset, asynchronous, active-high.
- req_valid_in  in  REQ_COUNT  requester i has a line to issue.
- req_abc_in  in  REQ_COUNT*LINE_WIDTH  line of requester i in bits [i*LINE_WIDTH +: LINE_WIDTH].
- req_use_new_c_in  in  REQ_COUNT  requester i's line loads a new c.
- req_ready_out  out  REQ_COUNT  one-hot grant (combinational); the line is accepted when valid&ready.
- abc_out  out  LINE_WIDTH  line issued to the FMAs.
- abc_valid_out  out  1  abc_out is valid.
- use_new_c_out  out  1  new-c flag for the issued line.
- result_line_in  in  RESULT_WIDTH  line_out from fma_write_buffer.
- result_valid_in  in  1  line_valid from fma_write_buffer.
- resp_line_out  out  RESULT_WIDTH  returned line.
- resp_valid_out  out  REQ_COUNT  one-hot; resp_line_out belongs to requester i.
- inflight_out  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy.
- unexpected_result_out  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - All outputs go to 0 and the round-robin pointer goes to 0.
  - Tag FIFO is emptied and the error flag is cleared.
  - Lines already in the FMA pipeline are forgotten; their later results fall under the unexpected-result rule.
- Grant (combinational):
  - can_issue = (inflight < TAG_DEPTH). A pop in the same cycle does NOT free a slot for issue (no bypass).
  - If can_issue, grant goes to the first i with req_valid_in[i], searching from ptr upward and wrapping modulo REQ_COUNT.
  - req_ready_out = one-hot of that i, or 0 when nothing is granted.
  - req_ready_out never depends on result_valid_in.
- Issue (registered):
  - Handshake in cycle t:
    - cycle t+1: abc_out = granted line, use_new_c_out = its flag, abc_valid_out = 1;
    - tag i is pushed at the t edge;
    - ptr becomes (i+1) mod REQ_COUNT.
  - Without a handshake: abc_valid_out = 0 and use_new_c_out = 0 next cycle; abc_out holds its last value; ptr is unchanged.
  - Issue latency is exactly 1 cycle.
- Return (registered):
  - If result_valid_in is high in cycle t and the FIFO is not empty:
    - the head tag k is popped;
    - cycle t+1: resp_line_out = result_line_in, resp_valid_out = one-hot(k).
  - Otherwise resp_valid_out = 0 and resp_line_out holds.
  - Responses have no backpressure; requesters must accept them in the cycle they are presented.
  - Results return in issue order, because the FMA pipeline is in order.
- Unexpected result:
  - result_valid_in with an empty FIFO: the line is dropped, resp_valid_out stays 0, and unexpected_result_out sets to 1.
  - The flag stays set until reset.
- Simultaneous push and pop: occupancy is unchanged, and both take effect in the same cycle.
- Occupancy:
  - inflight_out is registered and reflects the count after each edge.
  - Range is 0..TAG_DEPTH.
  - FIFO read and write pointers wrap modulo TAG_DEPTH.
- Full: with inflight == TAG_DEPTH, all req_ready_out are 0 and no push occurs. Pending requesters keep their valid asserted.
- Requester side: a requester may change req_abc_in while not granted. Once valid is asserted it must stay high until the handshake.

Test Plan:
- Reset, then set req_valid_in=2'b11 continuously (REQ_COUNT=2) -> grants alternate 0,1,0,1. abc_valid_out is high every cycle from cycle 2, with abc_out matching the alternating sources.
- Only requester 1 valid, line 96'hA5, use_new_c=1 -> req_ready_out=2'b10 in the same cycle. Next cycle: abc_out=96'hA5, use_new_c_out=1, inflight_out=1.
- TAG_DEPTH=4: issue 4 lines with no results -> req_ready_out=0 and inflight_out=4. One result_valid_in pulse -> resp_valid_out one cycle later for the first issuer, inflight_out=3, and ready is re-granted the cycle after the pop, not the same cycle.
- Issue order 0,1,1,0, then 4 results with payloads R0..R3 -> resp_valid_out = 01,10,10,01 with resp_line_out = R0..R3 respectively.
- result_valid_in with an empty FIFO -> unexpected_result_out=1, resp_valid_out=0. The flag stays 1 until rst_in.
- Assert rst_in asynchronously with 3 lines in flight -> outputs are 0 immediately and inflight_out=0. The 3 late results set unexpected_result_out.

Source files
------------

// File: rtl/fma_issue_arbiter.sv
// fma_issue_arbiter: round-robin share of the FMA issue port, with a tag FIFO
// that routes each returned result line back to the requester that issued it.
module fma_issue_arbiter #(
    parameter int REQ_COUNT    = 2,
    parameter int LINE_WIDTH   = 96,
    parameter int RESULT_WIDTH = 96,
    parameter int TAG_DEPTH    = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [REQ_COUNT-1:0]            req_valid_in,
    input  logic [REQ_COUNT*LINE_WIDTH-1:0] req_abc_in,
    input  logic [REQ_COUNT-1:0]            req_use_new_c_in,
    output logic [REQ_COUNT-1:0]            req_ready_out,
    output logic [LINE_WIDTH-1:0]           abc_out,
    output logic                            abc_valid_out,
    output logic                            use_new_c_out,
    input  logic [RESULT_WIDTH-1:0]         result_line_in,
    input  logic                            result_valid_in,
    output logic [RESULT_WIDTH-1:0]         resp_line_out,
    output logic [REQ_COUNT-1:0]            resp_valid_out,
    output logic [$clog2(TAG_DEPTH):0]      inflight_out,
    output logic                            unexpected_result_out
);
    localparam int PW = $clog2(REQ_COUNT);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] ptr, gnt_idx;
    logic          gnt_any, can_issue, push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] tag_mem [TAG_DEPTH];

    always_comb begin
        int idx;
        idx = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx = (int'(ptr) + k) % REQ_COUNT;
            if (!gnt_any && req_valid_in[PW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    // ready is gated by reset so every output reads 0 while rst_in is high
    assign can_issue     = (inflight_out < CW'(TAG_DEPTH)) && !rst_in;
    assign req_ready_out = (gnt_any && can_issue) ? REQ_COUNT'(1) << gnt_idx : '0;
    assign push          = |(req_valid_in & req_ready_out);
    assign pop           = result_valid_in && (inflight_out != '0);

    always_ff @(posedge clk_in)
        if (push) tag_mem[wr_ptr] <= gnt_idx;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr                   <= '0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            inflight_out          <= '0;
            abc_out               <= '0;
            abc_valid_out         <= 1'b0;
            use_new_c_out         <= 1'b0;
            resp_line_out         <= '0;
            resp_valid_out        <= '0;
            unexpected_result_out <= 1'b0;
        end else begin
            abc_valid_out         <= push;
            use_new_c_out         <= push && req_use_new_c_in[gnt_idx];
            resp_valid_out        <= pop ? REQ_COUNT'(1) << tag_mem[rd_ptr] : '0;
            inflight_out          <= inflight_out + CW'(push) - CW'(pop);
            unexpected_result_out <= unexpected_result_out | (result_valid_in && inflight_out == '0);
            if (push) begin
                abc_out <= req_abc_in[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
                ptr     <= (gnt_idx == PW'(REQ_COUNT - 1)) ? '0 : gnt_idx + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                resp_line_out <= result_line_in;
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// tb_fma_issue_arbiter: directed scenarios for fma_issue_arbiter with
// REQ_COUNT=2 and TAG_DEPTH=4; inputs change and outputs are sampled on negedge.
module tb_fma_issue_arbiter;
    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [1:0]   req_valid_in = '0;
    logic [191:0] req_abc_in = '0;
    logic [1:0]   req_use_new_c_in = '0;
    logic [1:0]   req_ready_out;
    logic [95:0]  abc_out;
    logic         abc_valid_out;
    logic         use_new_c_out;
    logic [95:0]  result_line_in = '0;
    logic         result_valid_in = 1'b0;
    logic [95:0]  resp_line_out;
    logic [1:0]   resp_valid_out;
    logic [2:0]   inflight_out;
    logic         unexpected_result_out;

    int checks = 0;
    int passed = 0;

    localparam logic [95:0] L0 = 96'h0000_1111_2222_3333_4444_5555;
    localparam logic [95:0] L1 = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

    fma_issue_arbiter #(.REQ_COUNT(2), .LINE_WIDTH(96), .RESULT_WIDTH(96), .TAG_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_abc_in(req_abc_in),
        .req_use_new_c_in(req_use_new_c_in), .req_ready_out(req_ready_out), .abc_out(abc_out),
        .abc_valid_out(abc_valid_out), .use_new_c_out(use_new_c_out), .result_line_in(result_line_in),
        .result_valid_in(result_valid_in), .resp_line_out(resp_line_out), .resp_valid_out(resp_valid_out),
        .inflight_out(inflight_out), .unexpected_result_out(unexpected_result_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic test_reset();
        rst_in = 1'b1;
        req_valid_in = 2'b11;
        repeat (2) @(negedge clk_in);
        checks++; if (req_ready_out !== 2'b00) $display("FAIL rst_ready got %b exp 00", req_ready_out); else passed++;
        checks++; if (abc_valid_out !== 1'b0) $display("FAIL rst_abc_valid got %b exp 0", abc_valid_out); else passed++;
        checks++; if (inflight_out !== 3'd0) $display("FAIL rst_inflight got %0d exp 0", inflight_out); else passed++;
        checks++; if (resp_valid_out !== 2'b00) $display("FAIL rst_resp_valid got %b exp 00", resp_valid_out); else passed++;
        checks++; if (unexpected_result_out !== 1'b0) $display("FAIL rst_unexpected got %b exp 0", unexpected_result_out); else passed++;
        checks++; if (abc_out !== 96'd0) $display("FAIL rst_abc_out got %h exp 0", abc_out); else passed++;
        req_valid_in = 2'b00;
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_single();
        req_abc_in[96 +: 96] = 96'hA5;
        req_use_new_c_in = 2'b10;
        req_valid_in = 2'b10;
        #1;
        checks++; if (req_ready_out !== 2'b10) $display("FAIL single_ready got %b exp 10", req_ready_out); else passed++;
        @(negedge clk_in);
        req_valid_in = 2'b00;
        checks++; if (abc_out !== 96'hA5) $display("FAIL single_abc got %h exp a5", abc_out); else passed++;
        checks++; if (use_new_c_out !== 1'b1) $display("FAIL single_new_c got %b exp 1", use_new_c_out); else passed++;
        checks++; if (abc_valid_out !== 1'b1) $display("FAIL single_abc_valid got %b exp 1", abc_valid_out); else passed++;
        checks++; if (inflight_out !== 3'd1) $display("FAIL single_inflight got %0d exp 1", inflight_out); else passed++;
        result_line_in = 96'hC0;
        result_valid_in = 1'b1;
        @(negedge clk_in);
        result_valid_in = 1'b0;
        checks++; if (resp_valid_out !== 2'b10) $display("FAIL single_resp_valid got %b exp 10", resp_valid_out); else passed++;
        checks++; if (resp_line_out !== 96'hC0) $display("FAIL single_resp_line got %h exp c0", resp_line_out); else passed++;
        checks++; if (inflight_out !== 3'd0) $display("FAIL single_drain got %0d exp 0", inflight_out); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        req_abc_in = {L1, L0};
        req_use_new_c_in = 2'b10;
        req_valid_in = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            e = 2'b01 << (i % 2);
            checks++; if (req_ready_out !== e) $display("FAIL rr_ready%0d got %b exp %b", i, req_ready_out, e); else passed++;
            @(negedge clk_in);
            checks++; if (abc_valid_out !== 1'b1) $display("FAIL rr_abc_valid%0d got %b exp 1", i, abc_valid_out); else passed++;
            checks++; if (abc_out !== (i % 2 == 1 ? L1 : L0)) $display("FAIL rr_abc%0d got %h", i, abc_out); else passed++;
            checks++; if (use_new_c_out !== e[1]) $display("FAIL rr_new_c%0d got %b exp %b", i, use_new_c_out, e[1]); else passed++;
            checks++; if (inflight_out !== 3'(i + 1)) $display("FAIL rr_inflight%0d got %0d exp %0d", i, inflight_out, i + 1); else passed++;
        end
        checks++; if (req_ready_out !== 2'b00) $display("FAIL full_ready got %b exp 00", req_ready_out); else passed++;
        @(negedge clk_in);
        checks++; if (abc_valid_out !== 1'b0) $display("FAIL full_abc_valid got %b exp 0", abc_valid_out); else passed++;
        checks++; if (use_new_c_out !== 1'b0) $display("FAIL full_new_c got %b exp 0", use_new_c_out); else passed++;
        checks++; if (abc_out !== L1) $display("FAIL full_abc_hold got %h exp %h", abc_out, L1); else passed++;
        checks++; if (inflight_out !== 3'd4) $display("FAIL full_inflight got %0d exp 4", inflight_out); else passed++;
    endtask

    task automatic test_full_pop();
        logic [1:0] tags [3] = '{2'b10, 2'b01, 2'b10};
        result_line_in = 96'hF00D_0000;
        result_valid_in = 1'b1;
        #1;
        checks++; if (req_ready_out !== 2'b00) $display("FAIL nobypass_ready got %b exp 00", req_ready_out); else passed++;
        @(negedge clk_in);
        result_valid_in = 1'b0;
        #1;
        checks++; if (resp_valid_out !== 2'b01) $display("FAIL pop_resp_valid got %b exp 01", resp_valid_out); else passed++;
        checks++; if (resp_line_out !== 96'hF00D_0000) $display("FAIL pop_resp_line got %h", resp_line_out); else passed++;
        checks++; if (inflight_out !== 3'd3) $display("FAIL pop_inflight got %0d exp 3", inflight_out); else passed++;
        checks++; if (req_ready_out !== 2'b01) $display("FAIL regrant_ready got %b exp 01", req_ready_out); else passed++;
        req_valid_in = 2'b00;
        for (int k = 0; k < 3; k++) begin
            result_line_in = 96'hF00D_0001 + 96'(k);
            result_valid_in = 1'b1;
            @(negedge clk_in);
            checks++; if (resp_valid_out !== tags[k]) $display("FAIL drain_resp%0d got %b exp %b", k, resp_valid_out, tags[k]); else passed++;
            checks++; if (resp_line_out !== 96'hF00D_0001 + 96'(k)) $display("FAIL drain_line%0d got %h", k, resp_line_out); else passed++;
            checks++; if (inflight_out !== 3'(2 - k)) $display("FAIL drain_inflight%0d got %0d exp %0d", k, inflight_out, 2 - k); else passed++;
        end
        result_valid_in = 1'b0;
        @(negedge clk_in);
        checks++; if (resp_valid_out !== 2'b00) $display("FAIL idle_resp got %b exp 00", resp_valid_out); else passed++;
    endtask

    task automatic test_order();
        logic [1:0] ov [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            req_valid_in = ov[i];
            #1;
            checks++; if (req_ready_out !== ov[i]) $display("FAIL order_ready%0d got %b exp %b", i, req_ready_out, ov[i]); else passed++;
            @(negedge clk_in);
        end
        req_valid_in = 2'b00;
        for (int i = 0; i < 4; i++) begin
            result_line_in = 96'hBEEF_0000 + 96'(i);
            result_valid_in = 1'b1;
            @(negedge clk_in);
            checks++; if (resp_valid_out !== ov[i]) $display("FAIL order_resp%0d got %b exp %b", i, resp_valid_out, ov[i]); else passed++;
            checks++; if (resp_line_out !== 96'hBEEF_0000 + 96'(i)) $display("FAIL order_line%0d got %h", i, resp_line_out); else passed++;
        end
        result_valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid_in = 2'b01;
        #1;
        checks++; if (req_ready_out !== 2'b01) $display("FAIL b2b_ready0 got %b exp 01", req_ready_out); else passed++;
        @(negedge clk_in);
        req_valid_in = 2'b10;
        result_line_in = 96'h7070;
        result_valid_in = 1'b1;
        #1;
        checks++; if (req_ready_out !== 2'b10) $display("FAIL b2b_ready1 got %b exp 10", req_ready_out); else passed++;
        @(negedge clk_in);
        req_valid_in = 2'b00;
        checks++; if (inflight_out !== 3'd1) $display("FAIL b2b_inflight got %0d exp 1", inflight_out); else passed++;
        checks++; if (resp_valid_out !== 2'b01) $display("FAIL b2b_resp got %b exp 01", resp_valid_out); else passed++;
        checks++; if (abc_out !== L1 || abc_valid_out !== 1'b1) $display("FAIL b2b_abc got %h/%b exp %h/1", abc_out, abc_valid_out, L1); else passed++;
        result_line_in = 96'h7171;
        @(negedge clk_in);
        result_valid_in = 1'b0;
        checks++; if (resp_valid_out !== 2'b10) $display("FAIL b2b_resp2 got %b exp 10", resp_valid_out); else passed++;
        checks++; if (inflight_out !== 3'd0) $display("FAIL b2b_inflight2 got %0d exp 0", inflight_out); else passed++;
    endtask

    task automatic test_unexpected();
        result_line_in = 96'hBAD;
        result_valid_in = 1'b1;
        @(negedge clk_in);
        result_valid_in = 1'b0;
        checks++; if (resp_valid_out !== 2'b00) $display("FAIL unexp_resp got %b exp 00", resp_valid_out); else passed++;
        checks++; if (unexpected_result_out !== 1'b1) $display("FAIL unexp_flag got %b exp 1", unexpected_result_out); else passed++;
        checks++; if (resp_line_out !== 96'h7171) $display("FAIL unexp_line_hold got %h exp 7171", resp_line_out); else passed++;
        checks++; if (inflight_out !== 3'd0) $display("FAIL unexp_inflight got %0d exp 0", inflight_out); else passed++;
        repeat (3) @(negedge clk_in);
        checks++; if (unexpected_result_out !== 1'b1) $display("FAIL unexp_sticky got %b exp 1", unexpected_result_out); else passed++;
    endtask

    task automatic test_async_reset();
        req_valid_in = 2'b11;
        repeat (3) @(negedge clk_in);
        checks++; if (inflight_out !== 3'd3) $display("FAIL ar_pre_inflight got %0d exp 3", inflight_out); else passed++;
        #2 rst_in = 1'b1;
        #1;
        checks++; if (inflight_out !== 3'd0) $display("FAIL ar_inflight got %0d exp 0", inflight_out); else passed++;
        checks++; if (abc_valid_out !== 1'b0) $display("FAIL ar_abc_valid got %b exp 0", abc_valid_out); else passed++;
        checks++; if (abc_out !== 96'd0) $display("FAIL ar_abc got %h exp 0", abc_out); else passed++;
        checks++; if (req_ready_out !== 2'b00) $display("FAIL ar_ready got %b exp 00", req_ready_out); else passed++;
        checks++; if (unexpected_result_out !== 1'b0) $display("FAIL ar_flag got %b exp 0", unexpected_result_out); else passed++;
        checks++; if (resp_line_out !== 96'd0) $display("FAIL ar_resp_line got %h exp 0", resp_line_out); else passed++;
        req_valid_in = 2'b00;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            result_line_in = 96'h1A7E + 96'(k);
            result_valid_in = 1'b1;
            @(negedge clk_in);
            checks++; if (resp_valid_out !== 2'b00) $display("FAIL late_resp%0d got %b exp 00", k, resp_valid_out); else passed++;
            checks++; if (unexpected_result_out !== 1'b1) $display("FAIL late_flag%0d got %b exp 1", k, unexpected_result_out); else passed++;
        end
        result_valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_pop();
        test_order();
        test_back_to_back();
        test_unexpected();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
